router_fifo_16x9: RTL and testbench

//   Per-destination packet FIFO of the 1x3 router; one instance per output port.

---
 rtl/router_fifo_16x9.sv | 79 +++++++
 tb/tb_router_fifo_16x9.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/router_fifo_16x9.sv
// Per-destination packet FIFO of the 1x3 router: stores {lfd, byte} words, tracks the
// remaining length of the packet being drained and releases data_out once it is done.
module router_fifo_16x9 #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             read_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   output wire  [WIDTH-1:0] data_out,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH:0]   mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [5:0]       count_reg;
   logic [WIDTH-1:0] data_reg;
   logic             drive_reg;

   logic [WIDTH:0]   rd_word;
   logic             rd_ok;
   logic             wr_ok;
   logic             hdr_rd;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg == {~rd_ptr_reg[AW], rd_ptr_reg[AW-1:0]});
   assign rd_word = mem[rd_ptr_reg[AW-1:0]];
   assign rd_ok   = read_enb && !empty;
   // A read in the same cycle frees the slot, so a write into a full FIFO is still taken.
   assign wr_ok   = write_enb && (!full || rd_ok);
   assign hdr_rd  = rd_ok && rd_word[WIDTH];

   // Bus is released between packets so the shared output can be tri-stated.
   assign data_out = drive_reg ? data_reg : {WIDTH{1'bz}};

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         data_reg   <= '0;
         drive_reg  <= 1'b1;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (soft_reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         data_reg   <= '0;
         drive_reg  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= {lfd_state, data_in};
            wr_ptr_reg              <= wr_ptr_reg + 1'b1;
         end
         if (rd_ok) begin
            data_reg   <= rd_word[WIDTH-1:0];
            drive_reg  <= 1'b1;
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
            // Header bits [7:2] hold the payload length; +1 accounts for the parity byte.
            if (rd_word[WIDTH])
               count_reg <= rd_word[WIDTH-1:WIDTH-6] + 6'd1;
            else if (count_reg != 6'd0)
               count_reg <= count_reg - 6'd1;
         end
         if (count_reg == 6'd0 && !hdr_rd)
            drive_reg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_router_fifo_16x9.sv
// Directed bench for router_fifo_16x9: reset, flush, fill/drain of one packet,
// streaming read/write with wrap, and reset in the middle of a packet.
module tb_router_fifo_16x9;

   logic       clock = 1'b0;
   logic       resetn;
   logic       soft_reset;
   logic       write_enb;
   logic       read_enb;
   logic       lfd_state;
   logic [7:0] data_in;
   wire  [7:0] data_out;
   logic       empty;
   logic       full;

   int tests = 0;
   int fails = 0;

   logic [7:0] pkt  [16];
   logic [7:0] vals [40];
   logic [7:0] zz;

   router_fifo_16x9 dut (
      .clock      (clock),
      .resetn     (resetn),
      .soft_reset (soft_reset),
      .write_enb  (write_enb),
      .read_enb   (read_enb),
      .lfd_state  (lfd_state),
      .data_in    (data_in),
      .data_out   (data_out),
      .empty      (empty),
      .full       (full)
   );

   always #5 clock = ~clock;

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the rising edge.
   task automatic step(input logic we, input logic re, input logic lfd, input logic [7:0] d);
      write_enb = we;
      read_enb  = re;
      lfd_state = lfd;
      data_in   = d;
      @(posedge clock);
      #1;
      $display("[TB] t=%0t we=%b re=%b lfd=%b din=%h -> dout=%h empty=%b full=%b",
               $time, we, re, lfd, d, data_out, empty, full);
   endtask

   initial begin
      zz         = 8'hzz;
      resetn     = 1'b0;
      soft_reset = 1'b0;
      write_enb  = 1'b0;
      read_enb   = 1'b0;
      lfd_state  = 1'b0;
      data_in    = 8'h00;

      // 1. hard reset
      step(0, 0, 0, 8'h00);
      chk1("rst_empty", empty, 1'b1);
      chk1("rst_full", full, 1'b0);
      chk8("rst_dout", data_out, 8'h00);
      resetn = 1'b1;

      // 2. soft reset discards buffered bytes
      step(1, 0, 0, 8'hA1);
      step(1, 0, 0, 8'hA2);
      step(1, 0, 0, 8'hA3);
      chk1("pre_soft_empty", empty, 1'b0);
      soft_reset = 1'b1;
      step(0, 0, 0, 8'h00);
      soft_reset = 1'b0;
      chk1("soft_empty", empty, 1'b1);
      chk1("soft_full", full, 1'b0);
      chk8("soft_dout", data_out, zz);
      step(0, 1, 0, 8'h00);
      chk1("soft_still_empty", empty, 1'b1);
      chk8("soft_read_ignored", data_out, zz);

      // 3. fill with one 16-byte packet; 17th write dropped
      pkt[0]  = 8'h39;
      pkt[15] = 8'h00;
      for (int i = 1; i < 15; i++) pkt[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 15; i++) pkt[15] = pkt[15] ^ pkt[i];
      for (int i = 0; i < 16; i++) begin
         step(1, 0, (i == 0), pkt[i]);
         if (i == 14) chk1("fill15_full", full, 1'b0);
      end
      chk1("fill16_full", full, 1'b1);
      chk1("fill16_empty", empty, 1'b0);
      step(1, 0, 0, 8'hEE);
      chk1("drop17_full", full, 1'b1);

      // 4. drain the packet, then bus releases
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 0, 8'h00);
         chk8($sformatf("drain%0d_dout", i), data_out, pkt[i]);
         chk1($sformatf("drain%0d_empty", i), empty, (i == 15));
         chk1($sformatf("drain%0d_full", i), full, 1'b0);
      end
      step(0, 1, 0, 8'h00);
      chk8("drain_release", data_out, zz);

      // 5. streaming: header 8'h98 -> 38 payload + parity = 39 bytes after header
      vals[0] = 8'h98;
      for (int i = 1; i < 40; i++) vals[i] = 8'($urandom_range(0, 255));
      for (int k = 0; k <= 40; k++) begin
         step((k < 40), 1, (k == 0), (k < 40) ? vals[k] : 8'h00);
         if (k >= 1) chk8($sformatf("stream%0d_dout", k), data_out, vals[k-1]);
         chk1($sformatf("stream%0d_empty", k), empty, (k == 40));
         chk1($sformatf("stream%0d_full", k), full, 1'b0);
      end

      // 6. reset mid-packet (count at 7), then a fresh header reloads the count
      step(1, 0, 1, 8'h28);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h50 + 8'(i));
      step(0, 1, 0, 8'h00);
      chk8("mid_hdr", data_out, 8'h28);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00);
      chk8("mid_pay4", data_out, 8'h53);
      resetn = 1'b0;
      step(0, 0, 0, 8'h00);
      resetn = 1'b1;
      chk8("mid_rst_dout", data_out, 8'h00);
      chk1("mid_rst_empty", empty, 1'b1);
      chk1("mid_rst_full", full, 1'b0);
      step(1, 0, 1, 8'h08);
      chk8("idle_after_rst", data_out, zz);
      step(1, 0, 0, 8'hC1);
      step(1, 0, 0, 8'hC2);
      step(1, 0, 0, 8'hC3);
      step(0, 1, 0, 8'h00);
      chk8("new_hdr", data_out, 8'h08);
      step(0, 1, 0, 8'h00);
      chk8("new_pay0", data_out, 8'hC1);
      step(0, 1, 0, 8'h00);
      chk8("new_pay1", data_out, 8'hC2);
      step(0, 1, 0, 8'h00);
      chk8("new_parity", data_out, 8'hC3);
      chk1("new_empty", empty, 1'b1);
      step(0, 1, 0, 8'h00);
      chk8("new_release", data_out, zz);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
